// File: rtl/uart_word_assembler.sv
// Rebuilds WORD_BYTES-wide words from a UART byte stream framed as
// sync byte, data bytes (MSB first) and an XOR checksum byte.
module uart_word_assembler #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         WORD_BYTES     = 4,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic [7:0]              i_data,
    input  logic                    i_ready_to_read,
    output logic [8*WORD_BYTES-1:0] o_word,
    output logic                    o_word_valid,
    output logic                    o_frame_error,
    output logic                    o_busy
);

    localparam int WORD_W = 8 * WORD_BYTES;
    localparam int IDX_W  = $clog2(WORD_BYTES + 1);
    localparam int GAP_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_CHECK
    } state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  shift_q, shift_d;
    logic [7:0]         acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic               word_valid_q, word_valid_d;
    logic               frame_error_q, frame_error_d;
    logic               busy_q, busy_d;
    logic               timeout_hit;

    // A strobe in the same cycle as the limit always wins over the timeout.
    assign timeout_hit = (state_q != ST_IDLE) && !i_ready_to_read && (gap_q == GAP_LIMIT);

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        acc_d         = acc_q;
        idx_d         = idx_q;
        gap_d         = gap_q;
        word_d        = word_q;
        word_valid_d  = 1'b0;
        frame_error_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                gap_d = '0;
                if (i_ready_to_read && (i_data == SYNC_BYTE)) begin
                    shift_d = '0;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                if (i_ready_to_read) begin
                    shift_d = WORD_W'({shift_q, i_data});
                    acc_d   = acc_q ^ i_data;
                    gap_d   = '0;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_CHECK;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (timeout_hit) begin
                    frame_error_d = 1'b1;
                    gap_d         = '0;
                    idx_d         = '0;
                    state_d       = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            ST_CHECK: begin
                if (i_ready_to_read) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                    if (i_data == acc_q) begin
                        word_d       = shift_q;
                        word_valid_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    frame_error_d = 1'b1;
                    gap_d         = '0;
                    state_d       = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            default: begin
                gap_d   = '0;
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            acc_q         <= '0;
            idx_q         <= '0;
            gap_q         <= '0;
            word_q        <= '0;
            word_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            acc_q         <= acc_d;
            idx_q         <= idx_d;
            gap_q         <= gap_d;
            word_q        <= word_d;
            word_valid_q  <= word_valid_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
        end
    end

    assign o_word        = word_q;
    assign o_word_valid  = word_valid_q;
    assign o_frame_error = frame_error_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Randomized bench for uart_word_assembler against a byte-queue frame model.
module tb_uart_word_assembler;

    localparam int         WB   = 4;
    localparam int         TO   = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    logic          clk = 1'b0;
    logic          i_reset = 1'b0;
    logic [7:0]    i_data = 8'h00;
    logic          i_ready_to_read = 1'b0;
    logic [31:0]   o_word;
    logic          o_word_valid;
    logic          o_frame_error;
    logic          o_busy;

    uart_word_assembler #(
        .SYNC_BYTE     (SYNC),
        .WORD_BYTES    (WB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk            (clk),
        .i_reset        (i_reset),
        .i_data         (i_data),
        .i_ready_to_read(i_ready_to_read),
        .o_word         (o_word),
        .o_word_valid   (o_word_valid),
        .o_frame_error  (o_frame_error),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_err_cyc = -1;
    int n_valid = 0;
    int n_err   = 0;

    // Reference model: frame in progress, bytes received so far, idle edges since last byte.
    bit          m_in_frame = 1'b0;
    logic [7:0]  m_bytes[$];
    int          m_idle = 0;
    logic [31:0] m_word = '0;
    bit          m_valid = 1'b0;
    bit          m_err = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 1'b0;
        m_bytes.delete();
        m_idle  = 0;
        m_word  = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input bit s, input logic [7:0] d);
        logic [7:0]  x;
        logic [31:0] w;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (!m_in_frame) begin
            if (s && d == SYNC) begin
                m_in_frame = 1'b1;
                m_bytes.delete();
                m_idle = 0;
            end
        end else if (s) begin
            m_idle = 0;
            if (m_bytes.size() < WB) begin
                m_bytes.push_back(d);
            end else begin
                x = 8'h00;
                w = '0;
                foreach (m_bytes[i]) begin
                    x = x ^ m_bytes[i];
                    w = (w << 8) | 32'(m_bytes[i]);
                end
                if (x == d) begin
                    m_word  = w;
                    m_valid = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
                m_in_frame = 1'b0;
            end
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                m_err      = 1'b1;
                m_in_frame = 1'b0;
            end
        end
    endtask

    task automatic cycle(input bit s, input logic [7:0] d);
        @(negedge clk);
        i_ready_to_read = s;
        i_data          = d;
        @(posedge clk);
        model_step(s, d);
        cyc++;
        #1;
        check("word",  o_word,        m_word);
        check("valid", o_word_valid,  m_valid);
        check("error", o_frame_error, m_err);
        check("busy",  o_busy,        m_in_frame);
        if (o_frame_error) begin
            n_err++;
            last_err_cyc = cyc;
        end
        if (o_word_valid) n_valid++;
        i_ready_to_read = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) cycle(1'b0, 8'($urandom));
        cycle(1'b1, b);
    endtask

    task automatic send_frame(input logic [31:0] w, input logic [7:0] flip, input int gap);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        send_byte(SYNC, gap);
        for (int i = WB - 1; i >= 0; i--) begin
            b = w[8*i +: 8];
            x = x ^ b;
            send_byte(b, gap);
        end
        send_byte(x ^ flip, gap);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 i_reset = 1'b0;
        #1;
        model_reset();
        check("rst_word",  o_word,        32'h0);
        check("rst_valid", o_word_valid,  1'b0);
        check("rst_error", o_frame_error, 1'b0);
        check("rst_busy",  o_busy,        1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_reset = 1'b1;
    endtask

    initial begin
        int s_cyc;
        int kind;
        model_reset();
        #1;
        check("por_word",  o_word,        32'h0);
        check("por_valid", o_word_valid,  1'b0);
        check("por_error", o_frame_error, 1'b0);
        check("por_busy",  o_busy,        1'b0);
        repeat (2) @(negedge clk);
        i_reset = 1'b1;

        // Good frame with 10-cycle gaps
        n_valid = 0; n_err = 0;
        send_frame(32'h12345678, 8'h00, 10);
        cycle(1'b0, 8'h00);
        check("good_word",   o_word,  32'h12345678);
        check("good_nvalid", n_valid, 1);
        check("good_nerr",   n_err,   0);

        // Bad checksum (08 -> 09)
        n_valid = 0; n_err = 0;
        send_frame(32'h12345678, 8'h01, 3);
        cycle(1'b0, 8'h00);
        check("bad_nerr",   n_err,   1);
        check("bad_nvalid", n_valid, 0);
        check("bad_word",   o_word,  32'h12345678);
        check("bad_busy",   o_busy,  1'b0);

        // Garbage then sync
        n_valid = 0; n_err = 0;
        send_byte(8'h00, 3);
        send_byte(8'hFF, 3);
        send_byte(8'h5A, 3);
        send_frame(32'hDEADBEEF, 8'h00, 2);
        cycle(1'b0, 8'h00);
        check("garb_word",   o_word,  32'hDEADBEEF);
        check("garb_nvalid", n_valid, 1);
        check("garb_nerr",   n_err,   0);

        // Timeout after a partial frame
        n_valid = 0; n_err = 0;
        send_byte(SYNC, 2);
        send_byte(8'h01, 1);
        s_cyc = cyc;
        repeat (20) cycle(1'b0, 8'h00);
        check("to_latency", last_err_cyc - s_cyc, 16);
        check("to_nerr",    n_err,  1);
        check("to_busy",    o_busy, 1'b0);
        check("to_word",    o_word, 32'hDEADBEEF);

        // Strobes just before and exactly at the timeout limit keep the frame alive
        n_valid = 0; n_err = 0;
        send_byte(SYNC, 1);
        send_byte(8'h01, 1);
        send_byte(8'h02, 14);
        send_byte(8'h03, 15);
        send_byte(8'h04, 0);
        send_byte(8'h04, 5);
        cycle(1'b0, 8'h00);
        check("near_to_nerr",   n_err,   0);
        check("near_to_nvalid", n_valid, 1);
        check("near_to_word",   o_word,  32'h01020304);

        // Back-to-back frames on consecutive strobes
        n_valid = 0; n_err = 0;
        send_frame(32'hCAFEF00D, 8'h00, 0);
        send_frame(32'h0BADC0DE, 8'h00, 0);
        cycle(1'b0, 8'h00);
        check("b2b_nvalid", n_valid, 2);
        check("b2b_word",   o_word,  32'h0BADC0DE);

        // Reset mid-frame
        n_valid = 0; n_err = 0;
        send_byte(SYNC, 1);
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        do_reset();
        send_frame(32'h13572468, 8'h00, 1);
        cycle(1'b0, 8'h00);
        check("rstmid_nerr",   n_err,   0);
        check("rstmid_nvalid", n_valid, 1);
        check("rstmid_word",   o_word,  32'h13572468);

        // Randomized traffic
        for (int it = 0; it < 400; it++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2, 3: send_frame($urandom, 8'h00, $urandom_range(0, 3));
                4:          send_frame($urandom, 8'($urandom_range(1, 255)), $urandom_range(0, 2));
                5, 6:       send_byte(8'($urandom), $urandom_range(0, 4));
                7: begin
                    send_byte(SYNC, $urandom_range(0, 2));
                    repeat ($urandom_range(0, WB)) send_byte(8'($urandom), $urandom_range(0, 2));
                    repeat ($urandom_range(12, 18)) cycle(1'b0, 8'($urandom));
                end
                default: send_byte(8'($urandom), $urandom_range(13, 17));
            endcase
        end
        repeat (20) cycle(1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
